axi4lite_burst_ctrl: RTL and testbench
======================================

# axi4lite_burst_ctrl

Sequences a whole cache-line transfer as a series of single-beat AXI4-Lite transactions, because AXI4-Lite has no native bursts. The block sits between the cache FSM and the AXI4-Lite master ports. On a start request it issues BEATS consecutive reads (line refill) or writes (line writeback) at incrementing addresses. It moves each beat to or from the line buffer and pulses done after the last response.

## Interface
- ADDR_WIDTH, 64, AXI address width
- DATA_WIDTH, 32, AXI data width; bytes per beat = DATA_WIDTH/8
- BEATS, 16, beats per line; power of two, ≥ 2
- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_start  in  1  start a line transfer; sampled only in IDLE
- i_write  in  1  direction latched with i_start: 1 = writeback, 0 = refill
- i_base_addr  in  ADDR_WIDTH  line base address; latched with i_start; low log2(BEATS·DATA_WIDTH/8) bits forced to 0
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse, transfer complete
- o_error  out  1  sticky per transfer: any RRESP/BRESP ≠ OKAY; cleared on the next accepted i_start
- o_buf_idx  out  $clog2(BEATS)  current beat index into line buffer
- o_buf_we  out  1  refill write strobe to line buffer
- o_buf_wdata  out  DATA_WIDTH  refill data (= RDATA)
- i_buf_rdata  in  DATA_WIDTH  writeback data for beat o_buf_idx
- AR: o_araddr ADDR_WIDTH, o_arvalid, i_arready; R: i_rdata DATA_WIDTH, i_rresp 2, i_rvalid, o_rready
- AW: o_awaddr ADDR_WIDTH, o_awvalid, i_awready; W: o_wdata DATA_WIDTH, o_wstrb DATA_WIDTH/8, o_wvalid, i_wready; B: i_bresp 2, i_bvalid, o_bready

## Operation
- States:
  - IDLE
  - RD_ADDR
  - RD_DATA
  - WR_REQ
  - WR_RESP
  - DONE
- IDLE:
  - i_start=1 latches base, direction and clears o_error, count ← 0.
  - Then → RD_ADDR (i_write=0) or → WR_REQ (i_write=1).
- RD_ADDR:
  - o_arvalid=1, o_araddr = base + count·(DATA_WIDTH/8).
  - On i_arready → RD_DATA.
- RD_DATA:
  - o_rready=1.
  - On i_rvalid: o_buf_we=1 in that same cycle (combinational), o_buf_wdata=i_rdata, o_buf_idx=count.
  - On the same handshake: o_error |= (i_rresp≠0).
  - Then, if count = BEATS-1 → DONE, else count+1 → RD_ADDR.
- WR_REQ:
  - o_awvalid and o_wvalid rise together; o_awaddr is formed as for reads.
  - o_wdata = i_buf_rdata; o_wstrb = all ones.
  - Each VALID drops individually after its own handshake; simultaneous handshakes are allowed.
  - When both channels have completed → WR_RESP.
- WR_RESP:
  - o_bready=1.
  - On i_bvalid: o_error |= (i_bresp≠0).
  - Then the last-beat and count rule is as in RD_DATA: count = BEATS-1 → DONE, else count+1 → WR_REQ.
- DONE: o_done=1 for exactly one cycle, → IDLE.
- At most one transaction outstanding.
- VALID is never withdrawn before its handshake. Address and data stay stable while VALID is high.
- Count arithmetic is modulo BEATS. Address arithmetic is ADDR_WIDTH-bit, and no line crosses a wrap because of base alignment.
- An error response does not abort the transfer: all BEATS beats always complete.
- i_start while busy is ignored (no queueing).
- i_buf_rdata must be stable while o_wvalid is high. The block does not register it.

## Timing
- Reset values:
  - State IDLE, count 0.
  - o_busy, o_done, o_error, o_buf_we = 0.
  - All VALID/READY outputs = 0.
  - All address and data outputs = 0.
- Reset mid-transfer: next edge forces IDLE and the reset values. Outstanding AXI transactions are abandoned, which is allowed only under a system-wide reset.
- Start latency: i_start at cycle 0 → o_busy and first VALID at cycle 1.
- Zero-wait slave: 2 cycles per beat. For BEATS=16, the last response handshake is at cycle 32 and o_done is at cycle 33. o_busy is high in cycles 1–33 and low in cycle 34.
- Slave wait states add cycle-for-cycle to the latency.
- o_error is valid from the cycle o_done is high and holds until the next accepted start.

## Test plan
- Refill, zero-wait slave:
  - Stimulus: base 0x1000_0040, BEATS=16, DATA_WIDTH=32.
  - Response: ARADDR 0x1000_0040, 0x…44 … 0x…7C.
  - o_buf_we pulses 16 times with idx 0..15 and matching data.
  - o_done at cycle 33, o_error=0.
- Writeback, staggered ready:
  - Stimulus: i_awready at cycle 1 and i_wready at cycle 3 on every beat; BVALID 2 cycles later.
  - Response: no VALID drops early, WDATA equals i_buf_rdata[idx], exactly 16 B handshakes, one o_done pulse.
- Error response:
  - Stimulus: i_rresp=2'b10 on beat 5 only.
  - Response: all 16 beats complete, o_error=1 at o_done.
  - The next i_start clears o_error to 0.
- Start while busy: a second i_start pulse at cycle 10 is ignored; exactly one o_done; the direction latched at cycle 0 is kept.
- Reset mid-operation: i_rst at cycle 12 of a refill → cycle 13 IDLE with all outputs 0; a new start then runs the full 16 beats from count 0.
- Unaligned base: i_base_addr 0x1000_0047 → first ARADDR 0x1000_0040.

Source files
------------

// File: rtl/axi4lite_burst_ctrl_if.sv
// AXI4-Lite channel bundle between the line-transfer sequencer and the
// memory-side slave. Signal names keep the sequencer's point of view.
interface axi4lite_burst_ctrl_if #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 32
);
   // Read address / read data
   logic [ADDR_WIDTH-1:0]   o_araddr;
   logic                    o_arvalid;
   logic                    i_arready;
   logic [DATA_WIDTH-1:0]   i_rdata;
   logic [1:0]              i_rresp;
   logic                    i_rvalid;
   logic                    o_rready;
   // Write address / write data / write response
   logic [ADDR_WIDTH-1:0]   o_awaddr;
   logic                    o_awvalid;
   logic                    i_awready;
   logic [DATA_WIDTH-1:0]   o_wdata;
   logic [DATA_WIDTH/8-1:0] o_wstrb;
   logic                    o_wvalid;
   logic                    i_wready;
   logic [1:0]              i_bresp;
   logic                    i_bvalid;
   logic                    o_bready;

   modport master (
      output o_araddr, o_arvalid, input  i_arready,
      input  i_rdata, i_rresp, i_rvalid, output o_rready,
      output o_awaddr, o_awvalid, input  i_awready,
      output o_wdata, o_wstrb, o_wvalid, input  i_wready,
      input  i_bresp, i_bvalid, output o_bready
   );

   modport slave (
      input  o_araddr, o_arvalid, output i_arready,
      output i_rdata, i_rresp, i_rvalid, input  o_rready,
      input  o_awaddr, o_awvalid, output i_awready,
      input  o_wdata, o_wstrb, o_wvalid, output i_wready,
      output i_bresp, i_bvalid, input  o_bready
   );
endinterface

// File: rtl/axi4lite_burst_ctrl.sv
// Cache-line transfer sequencer: turns one start request into BEATS
// single-beat AXI4-Lite reads (refill) or writes (writeback) at
// incrementing addresses, one transaction outstanding at a time.
module axi4lite_burst_ctrl #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 32,
   parameter int BEATS      = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_start,
   input  logic                     i_write,
   input  logic [ADDR_WIDTH-1:0]    i_base_addr,
   output logic                     o_busy,
   output logic                     o_done,
   output logic                     o_error,
   output logic [$clog2(BEATS)-1:0] o_buf_idx,
   output logic                     o_buf_we,
   output logic [DATA_WIDTH-1:0]    o_buf_wdata,
   input  logic [DATA_WIDTH-1:0]    i_buf_rdata,
   axi4lite_burst_ctrl_if.master    axi
);
   localparam int IDX_W   = $clog2(BEATS);
   localparam int BYTES   = DATA_WIDTH / 8;
   localparam int BYTE_SH = $clog2(BYTES);
   localparam int OFF_W   = $clog2(BEATS * BYTES);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
      ~((ADDR_WIDTH'(1) << OFF_W) - ADDR_WIDTH'(1));
   localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BEATS - 1);

   typedef enum logic [2:0] {
      IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE
   } state_t;

   state_t                  state;
   logic [IDX_W-1:0]        count;
   logic [ADDR_WIDTH-1:0]   base_q;
   logic [ADDR_WIDTH-1:0]   start_base;
   logic [IDX_W-1:0]        count_nxt;
   logic [ADDR_WIDTH-1:0]   next_addr;
   logic                    aw_pending_nxt;
   logic                    w_pending_nxt;

   // Line-aligned base, next beat index (wraps modulo BEATS) and its address.
   assign start_base = i_base_addr & ALIGN_MASK;
   assign count_nxt  = count + IDX_W'(1);
   assign next_addr  = base_q + (ADDR_WIDTH'(count_nxt) << BYTE_SH);

   // A write channel stays pending until its own handshake.
   assign aw_pending_nxt = axi.o_awvalid & ~axi.i_awready;
   assign w_pending_nxt  = axi.o_wvalid  & ~axi.i_wready;

   // Line-buffer side: refill strobe is the R handshake itself, same cycle.
   // NOTE: continuous assigns with a full ternary cannot infer a latch; every output is always driven.
   assign o_buf_idx   = count;
   assign o_buf_we    = axi.o_rready & axi.i_rvalid;
   assign o_buf_wdata = o_buf_we ? axi.i_rdata : '0;

   // Writeback data comes straight from the line buffer while WVALID is up.
   assign axi.o_wdata = axi.o_wvalid ? i_buf_rdata : '0;
   assign axi.o_wstrb = axi.o_wvalid ? {BYTES{1'b1}} : {BYTES{1'b0}};

   // Control FSM: one transaction per beat, all handshake outputs registered.
   always_ff @(posedge i_clk) begin
      // NOTE: synchronous reset, and non-blocking assignments so every register sees pre-edge values.
      if (i_rst) begin
         state         <= IDLE;
         count         <= '0;
         base_q        <= '0;
         o_busy        <= 1'b0;
         o_done        <= 1'b0;
         o_error       <= 1'b0;
         axi.o_araddr  <= '0;
         axi.o_arvalid <= 1'b0;
         axi.o_rready  <= 1'b0;
         axi.o_awaddr  <= '0;
         axi.o_awvalid <= 1'b0;
         axi.o_wvalid  <= 1'b0;
         axi.o_bready  <= 1'b0;
      end else begin
         o_done <= 1'b0;
         case (state)
            IDLE: begin
               if (i_start) begin
                  base_q  <= start_base;
                  count   <= '0;
                  o_error <= 1'b0;
                  o_busy  <= 1'b1;
                  if (i_write) begin
                     state         <= WR_REQ;
                     axi.o_awaddr  <= start_base;
                     axi.o_awvalid <= 1'b1;
                     axi.o_wvalid  <= 1'b1;
                  end else begin
                     state         <= RD_ADDR;
                     axi.o_araddr  <= start_base;
                     axi.o_arvalid <= 1'b1;
                  end
               end
            end
            RD_ADDR: begin
               if (axi.i_arready) begin
                  axi.o_arvalid <= 1'b0;
                  axi.o_rready  <= 1'b1;
                  state         <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (axi.i_rvalid) begin
                  axi.o_rready <= 1'b0;
                  if (axi.i_rresp != 2'b00) o_error <= 1'b1;
                  if (count == LAST_BEAT) begin
                     state  <= DONE;
                     o_done <= 1'b1;
                  end else begin
                     count         <= count_nxt;
                     axi.o_araddr  <= next_addr;
                     axi.o_arvalid <= 1'b1;
                     state         <= RD_ADDR;
                  end
               end
            end
            WR_REQ: begin
               axi.o_awvalid <= aw_pending_nxt;
               axi.o_wvalid  <= w_pending_nxt;
               if (!aw_pending_nxt && !w_pending_nxt) begin
                  axi.o_bready <= 1'b1;
                  state        <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (axi.i_bvalid) begin
                  axi.o_bready <= 1'b0;
                  if (axi.i_bresp != 2'b00) o_error <= 1'b1;
                  if (count == LAST_BEAT) begin
                     state  <= DONE;
                     o_done <= 1'b1;
                  end else begin
                     count         <= count_nxt;
                     axi.o_awaddr  <= next_addr;
                     axi.o_awvalid <= 1'b1;
                     axi.o_wvalid  <= 1'b1;
                     state         <= WR_REQ;
                  end
               end
            end
            DONE: begin
               o_busy <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi4lite_burst_ctrl.sv
// Self-checking bench for axi4lite_burst_ctrl: bench-side AXI4-Lite slave
// tasks, scoreboard queues filled when stimulus is driven and drained when
// the DUT presents addresses, write data and line-buffer writes.
module tb_axi4lite_burst_ctrl;
   localparam int AW    = 64;
   localparam int DW    = 32;
   localparam int BEATS = 16;

   typedef struct packed {
      logic [3:0]    idx;
      logic [DW-1:0] data;
   } bufwr_t;

   logic          i_clk = 1'b0;
   logic          i_rst;
   logic          i_start;
   logic          i_write;
   logic [AW-1:0] i_base_addr;
   logic          o_busy;
   logic          o_done;
   logic          o_error;
   logic [3:0]    o_buf_idx;
   logic          o_buf_we;
   logic [DW-1:0] o_buf_wdata;
   logic [DW-1:0] i_buf_rdata;
   logic [DW-1:0] line_buf [BEATS];

   axi4lite_burst_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

   axi4lite_burst_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BEATS(BEATS)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_start     (i_start),
      .i_write     (i_write),
      .i_base_addr (i_base_addr),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_error     (o_error),
      .o_buf_idx   (o_buf_idx),
      .o_buf_we    (o_buf_we),
      .o_buf_wdata (o_buf_wdata),
      .i_buf_rdata (i_buf_rdata),
      .axi         (axi)
   );

   always #5 i_clk = ~i_clk;

   assign i_buf_rdata = line_buf[o_buf_idx];

   int n_vec     = 0;
   int n_err     = 0;
   int cyc       = 0;
   int done_cnt  = 0;
   int start_cyc = 0;
   int done_base = 0;

   logic [AW-1:0] exp_addr_q  [$];
   logic [DW-1:0] exp_wdata_q [$];
   bufwr_t        exp_buf_q   [$];

   always @(posedge i_clk) cyc++;
   always @(negedge i_clk) if (o_done) done_cnt++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // Kick off a transfer at a negedge (cycle 0); returns at negedge of cycle 1.
   task automatic start_xfer(input logic wr, input logic [AW-1:0] base);
      logic [AW-1:0] aligned;
      aligned = base & ~AW'(BEATS * DW / 8 - 1);
      exp_addr_q.delete();
      exp_wdata_q.delete();
      exp_buf_q.delete();
      for (int i = 0; i < BEATS; i++) begin
         exp_addr_q.push_back(aligned + AW'(i * 4));
         if (wr) begin
            line_buf[i] = $urandom;
            exp_wdata_q.push_back(line_buf[i]);
         end
      end
      done_base   = done_cnt;
      start_cyc   = cyc;
      i_start     = 1'b1;
      i_write     = wr;
      i_base_addr = base;
      @(negedge i_clk);
      i_start     = 1'b0;
      i_base_addr = 64'hDEAD_BEEF_0000_0FFF;
      n_vec++;
      if (o_busy !== 1'b1 || o_error !== 1'b0) begin
         n_err++;
         $display("FAIL start_latency: busy=%b error=%b, required busy=1 error=0 at cycle 1", o_busy, o_error);
      end
   endtask

   task automatic serve_read(input int beat, input int ar_wait, input int r_wait, input logic [1:0] resp);
      int            n;
      logic [AW-1:0] ea;
      bufwr_t        e;
      n = 0;
      while (!axi.o_arvalid && n < 40) begin @(negedge i_clk); n++; end
      n_vec++;
      if (!axi.o_arvalid) begin
         n_err++;
         $display("FAIL ar_timeout beat %0d: arvalid=%b, required 1", beat, axi.o_arvalid);
         return;
      end
      ea = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 'x;
      for (int w = 0; w <= ar_wait; w++) begin
         if (w > 0) @(negedge i_clk);
         n_vec++;
         if (axi.o_arvalid !== 1'b1 || axi.o_araddr !== ea || axi.o_awvalid !== 1'b0) begin
            n_err++;
            $display("FAIL araddr beat %0d: arvalid=%b araddr=%h awvalid=%b, required 1 %h 0",
                     beat, axi.o_arvalid, axi.o_araddr, axi.o_awvalid, ea);
         end
      end
      axi.i_arready = 1'b1;
      @(negedge i_clk);
      axi.i_arready = 1'b0;
      n = 0;
      while (!axi.o_rready && n < 40) begin @(negedge i_clk); n++; end
      for (int w = 0; w < r_wait; w++) begin
         n_vec++;
         if (o_buf_we !== 1'b0 || axi.o_rready !== 1'b1) begin
            n_err++;
            $display("FAIL r_wait beat %0d: buf_we=%b rready=%b, required 0 1", beat, o_buf_we, axi.o_rready);
         end
         @(negedge i_clk);
      end
      e.idx  = 4'(beat);
      e.data = $urandom;
      exp_buf_q.push_back(e);
      axi.i_rdata  = e.data;
      axi.i_rresp  = resp;
      axi.i_rvalid = 1'b1;
      #1;
      e = (exp_buf_q.size() > 0) ? exp_buf_q.pop_front() : 'x;
      n_vec++;
      if (o_buf_we !== 1'b1 || o_buf_idx !== e.idx || o_buf_wdata !== e.data) begin
         n_err++;
         $display("FAIL buf_write beat %0d: we=%b idx=%0d data=%h, required 1 %0d %h",
                  beat, o_buf_we, o_buf_idx, o_buf_wdata, e.idx, e.data);
      end
      @(negedge i_clk);
      axi.i_rvalid = 1'b0;
      axi.i_rresp  = 2'b00;
   endtask

   task automatic serve_write(input int beat, input int aw_wait, input int w_wait, input int b_wait,
                              input logic [1:0] resp);
      int            n;
      int            k;
      logic          aw_done;
      logic          w_done;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      n = 0;
      while (!(axi.o_awvalid && axi.o_wvalid) && n < 40) begin @(negedge i_clk); n++; end
      n_vec++;
      if (!(axi.o_awvalid && axi.o_wvalid)) begin
         n_err++;
         $display("FAIL wr_timeout beat %0d: awvalid=%b wvalid=%b, required 1 1", beat, axi.o_awvalid, axi.o_wvalid);
         return;
      end
      ea = (exp_addr_q.size() > 0)  ? exp_addr_q.pop_front()  : 'x;
      ed = (exp_wdata_q.size() > 0) ? exp_wdata_q.pop_front() : 'x;
      aw_done = 1'b0;
      w_done  = 1'b0;
      k = 0;
      while (!(aw_done && w_done) && k < 40) begin
         n_vec++;
         if (axi.o_awvalid !== !aw_done || axi.o_wvalid !== !w_done) begin
            n_err++;
            $display("FAIL valid_seq beat %0d cyc %0d: awvalid=%b wvalid=%b, required %b %b",
                     beat, k, axi.o_awvalid, axi.o_wvalid, !aw_done, !w_done);
         end
         if (!aw_done) begin
            n_vec++;
            if (axi.o_awaddr !== ea) begin
               n_err++;
               $display("FAIL awaddr beat %0d: got %h, required %h", beat, axi.o_awaddr, ea);
            end
         end
         if (!w_done) begin
            n_vec++;
            if (axi.o_wdata !== ed || axi.o_wstrb !== 4'hF) begin
               n_err++;
               $display("FAIL wdata beat %0d: got %h/%h, required %h/f", beat, axi.o_wdata, axi.o_wstrb, ed);
            end
         end
         axi.i_awready = !aw_done && (k >= aw_wait);
         axi.i_wready  = !w_done  && (k >= w_wait);
         if (axi.i_awready && axi.o_awvalid) aw_done = 1'b1;
         if (axi.i_wready  && axi.o_wvalid)  w_done  = 1'b1;
         @(negedge i_clk);
         k++;
      end
      axi.i_awready = 1'b0;
      axi.i_wready  = 1'b0;
      n_vec++;
      if (!(aw_done && w_done)) begin
         n_err++;
         $display("FAIL w_timeout beat %0d: aw_done=%b w_done=%b, required 1 1", beat, aw_done, w_done);
      end
      for (int w = 0; w <= b_wait; w++) begin
         if (w > 0) @(negedge i_clk);
         n_vec++;
         if (axi.o_bready !== 1'b1 || axi.o_awvalid !== 1'b0 || axi.o_wvalid !== 1'b0) begin
            n_err++;
            $display("FAIL bready beat %0d: bready=%b awvalid=%b wvalid=%b, required 1 0 0",
                     beat, axi.o_bready, axi.o_awvalid, axi.o_wvalid);
         end
      end
      axi.i_bresp  = resp;
      axi.i_bvalid = 1'b1;
      @(negedge i_clk);
      axi.i_bvalid = 1'b0;
      axi.i_bresp  = 2'b00;
   endtask

   // Expect o_done (at exp_cyc relative to start), the error flag, then IDLE.
   task automatic finish_xfer(input int exp_cyc, input logic exp_err);
      int n;
      n = 0;
      while (!o_done && n < 10) begin @(negedge i_clk); n++; end
      n_vec++;
      if (o_done !== 1'b1 || (cyc - start_cyc) !== exp_cyc || o_error !== exp_err || o_busy !== 1'b1) begin
         n_err++;
         $display("FAIL done: done=%b cycle=%0d error=%b busy=%b, required 1 %0d %b 1",
                  o_done, cyc - start_cyc, o_error, o_busy, exp_cyc, exp_err);
      end
      @(negedge i_clk);
      n_vec++;
      if (o_done !== 1'b0 || o_busy !== 1'b0 || o_error !== exp_err) begin
         n_err++;
         $display("FAIL after_done: done=%b busy=%b error=%b, required 0 0 %b", o_done, o_busy, o_error, exp_err);
      end
      repeat (3) @(negedge i_clk);
      n_vec++;
      if (done_cnt - done_base !== 1 || exp_addr_q.size() !== 0 || exp_wdata_q.size() !== 0) begin
         n_err++;
         $display("FAIL done_count: pulses=%0d addr_left=%0d wdata_left=%0d, required 1 0 0",
                  done_cnt - done_base, exp_addr_q.size(), exp_wdata_q.size());
      end
   endtask

   task automatic check_all_zero(input string tag);
      n_vec++;
      if ({o_busy, o_done, o_error, o_buf_we, axi.o_arvalid, axi.o_rready,
           axi.o_awvalid, axi.o_wvalid, axi.o_bready} !== 9'b0 ||
          axi.o_araddr !== '0 || axi.o_awaddr !== '0 || axi.o_wdata !== '0 ||
          axi.o_wstrb !== 4'h0 || o_buf_idx !== 4'd0 || o_buf_wdata !== '0) begin
         n_err++;
         $display("FAIL %s: flags=%b araddr=%h awaddr=%h wdata=%h idx=%0d, required all 0", tag,
                  {o_busy, o_done, o_error, o_buf_we, axi.o_arvalid, axi.o_rready,
                   axi.o_awvalid, axi.o_wvalid, axi.o_bready},
                  axi.o_araddr, axi.o_awaddr, axi.o_wdata, o_buf_idx);
      end
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      i_start = 1'b1;
      repeat (3) @(negedge i_clk);
      check_all_zero("reset_state");
      i_start = 1'b0;
      i_rst   = 1'b0;
      repeat (2) @(negedge i_clk);
      check_all_zero("idle_after_reset");
   endtask

   task automatic test_refill_zero_wait();
      start_xfer(1'b0, 64'h0000_0000_1000_0040);
      for (int b = 0; b < BEATS; b++) serve_read(b, 0, 0, 2'b00);
      finish_xfer(33, 1'b0);
   endtask

   task automatic test_writeback_staggered();
      start_xfer(1'b1, 64'h0000_0000_2000_0380);
      for (int b = 0; b < BEATS; b++) serve_write(b, 0, 2, 2, 2'b00);
      finish_xfer(97, 1'b0);
   endtask

   task automatic test_error_response();
      start_xfer(1'b0, 64'h0000_0000_4000_0100);
      for (int b = 0; b < BEATS; b++) serve_read(b, 1, 1, (b == 5) ? 2'b10 : 2'b00);
      finish_xfer(65, 1'b1);
      start_xfer(1'b1, 64'h0000_0000_4000_0200);
      for (int b = 0; b < BEATS; b++) serve_write(b, 0, 0, 0, 2'b00);
      finish_xfer(33, 1'b0);
   endtask

   task automatic test_start_while_busy();
      start_xfer(1'b0, 64'h0000_0000_5000_0000);
      fork
         begin
            repeat (9) @(negedge i_clk);
            i_start     = 1'b1;
            i_write     = 1'b1;
            i_base_addr = 64'h0000_0000_6000_0000;
            @(negedge i_clk);
            i_start     = 1'b0;
         end
      join_none
      for (int b = 0; b < BEATS; b++) serve_read(b, 0, 0, 2'b00);
      finish_xfer(33, 1'b0);
   endtask

   task automatic test_reset_mid();
      start_xfer(1'b0, 64'h0000_0000_3000_0000);
      for (int b = 0; b < 5; b++) serve_read(b, 0, 0, 2'b00);
      @(negedge i_clk);
      i_rst = 1'b1;
      @(negedge i_clk);
      check_all_zero("reset_mid_transfer");
      i_rst = 1'b0;
      @(negedge i_clk);
      start_xfer(1'b0, 64'h0000_0000_3000_0080);
      for (int b = 0; b < BEATS; b++) serve_read(b, 0, 0, 2'b00);
      finish_xfer(33, 1'b0);
   endtask

   task automatic test_unaligned();
      start_xfer(1'b0, 64'h0000_0000_1000_0047);
      for (int b = 0; b < BEATS; b++) serve_read(b, 0, 0, 2'b00);
      finish_xfer(33, 1'b0);
   endtask

   initial begin
      i_rst         = 1'b1;
      i_start       = 1'b0;
      i_write       = 1'b0;
      i_base_addr   = '0;
      axi.i_arready = 1'b0;
      axi.i_rdata   = '0;
      axi.i_rresp   = 2'b00;
      axi.i_rvalid  = 1'b0;
      axi.i_awready = 1'b0;
      axi.i_wready  = 1'b0;
      axi.i_bresp   = 2'b00;
      axi.i_bvalid  = 1'b0;
      for (int i = 0; i < BEATS; i++) line_buf[i] = '0;
      @(negedge i_clk);
      test_reset();
      test_refill_zero_wait();
      test_writeback_staggered();
      test_error_response();
      test_start_while_busy();
      test_reset_mid();
      test_unaligned();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
